// File: rtl/shift_add_seq_pkg.sv
// Shared constants for the bit-serial shift-and-add multiplier.
package shift_add_seq_pkg;

  localparam int unsigned DefaultWidth = 8;

endpackage

// File: rtl/shift_add_seq_sipo_shift_reg.sv
// Serial-in / parallel-out shift register with synchronous reset, clear and enable.
module sipo_shift_reg
  import shift_add_seq_pkg::*;
#(
  parameter int unsigned Width = DefaultWidth
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (clr_i) begin
      sr_d = '0;
    end else if (en_i) begin
      sr_d = {sr_q[Width-2:0], d_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q_o = sr_q;

endmodule

// File: rtl/shift_add_seq.sv
// Bit-serial coefficient multiplier: MSB-first serial word times a parallel-loaded
// coefficient, accumulated by double-and-add, modulo 2^WIDTH.
module shift_add_seq
  import shift_add_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             ParaLoad,
  input  logic [WIDTH-1:0] CoeffData,
  input  logic             SerialIn,
  input  logic             EnableShiftAdd,
  output logic [WIDTH-1:0] ShiftRegA,
  output logic [WIDTH-1:0] ShiftRegB,
  output logic [WIDTH-1:0] ParallelOut
);

  logic [WIDTH-1:0] coeff_q, coeff_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  // Overflow out of the top bit is intentionally dropped.
  always_comb begin
    coeff_d = coeff_q;
    acc_d   = acc_q;
    if (ParaLoad) begin
      coeff_d = CoeffData;
      acc_d   = '0;
    end else if (EnableShiftAdd) begin
      acc_d = {acc_q[WIDTH-2:0], 1'b0} + (SerialIn ? coeff_q : '0);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      coeff_q <= '0;
      acc_q   <= '0;
    end else begin
      coeff_q <= coeff_d;
      acc_q   <= acc_d;
    end
  end

  sipo_shift_reg #(
    .Width (WIDTH)
  ) u_capture (
    .clk_i (Clock),
    .rst_i (Reset),
    .clr_i (ParaLoad),
    .en_i  (EnableShiftAdd),
    .d_i   (SerialIn),
    .q_o   (ShiftRegB)
  );

  assign ShiftRegA   = coeff_q;
  assign ParallelOut = acc_q;

endmodule

// File: tb/tb_shift_add_seq.sv
// Self-checking bench for shift_add_seq against an arithmetic reference model.
module tb_shift_add_seq;

  logic       Clock = 1'b0;
  logic       Reset, ParaLoad, SerialIn, EnableShiftAdd;
  logic [7:0] CoeffData;
  logic [7:0] ShiftRegA, ShiftRegB, ParallelOut;

  int n_cmp = 0;
  int n_err = 0;
  int m_a = 0, m_b = 0, m_p = 0;

  shift_add_seq #(
    .WIDTH (8)
  ) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .ParaLoad       (ParaLoad),
    .CoeffData      (CoeffData),
    .SerialIn       (SerialIn),
    .EnableShiftAdd (EnableShiftAdd),
    .ShiftRegA      (ShiftRegA),
    .ShiftRegB      (ShiftRegB),
    .ParallelOut    (ParallelOut)
  );

  always #5 Clock = ~Clock;

  // Drive one cycle, let the edge happen, then advance the model.
  task automatic cycle(input bit rst, input bit ld, input int coeff, input bit en, input bit sin);
    Reset = rst; ParaLoad = ld; CoeffData = coeff[7:0]; EnableShiftAdd = en; SerialIn = sin;
    @(posedge Clock);
    #1;
    if (rst) begin
      m_a = 0; m_b = 0; m_p = 0;
    end else if (ld) begin
      m_a = coeff % 256; m_b = 0; m_p = 0;
    end else if (en) begin
      m_b = (m_b * 2 + (sin ? 1 : 0)) % 256;
      m_p = (m_p * 2 + (sin ? m_a : 0)) % 256;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'($urandom), int'($urandom_range(255)), 1'($urandom), 1'($urandom));
    end
    n_cmp += 3;
    if (ShiftRegA !== 8'h00) begin n_err++; $display("FAIL reset_a got %h want 00", ShiftRegA); end
    if (ShiftRegB !== 8'h00) begin n_err++; $display("FAIL reset_b got %h want 00", ShiftRegB); end
    if (ParallelOut !== 8'h00) begin
      n_err++; $display("FAIL reset_p got %h want 00", ParallelOut);
    end
  endtask

  task automatic test_basic();
    logic [7:0] steps [8] = '{8'h56, 8'hAC, 8'hAE, 8'hB2, 8'h64, 8'hC8, 8'hE6, 8'hCC};
    logic [7:0] word = 8'hB2;
    cycle(1'b0, 1'b1, 'h56, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, 0, 1'b1, word[7-i]);
      n_cmp++;
      if (ParallelOut !== steps[i]) begin
        n_err++; $display("FAIL basic_step%0d got %h want %h", i, ParallelOut, steps[i]);
      end
    end
    n_cmp += 2;
    if (ShiftRegB !== 8'hB2) begin n_err++; $display("FAIL basic_b got %h want b2", ShiftRegB); end
    if (ShiftRegA !== 8'h56) begin n_err++; $display("FAIL basic_a got %h want 56", ShiftRegA); end
  endtask

  task automatic test_wrap_and_small();
    logic [7:0] word;
    logic [7:0] coeffs [3] = '{8'hFF, 8'h03, 8'h00};
    logic [7:0] words  [3];
    logic [7:0] want   [3] = '{8'h01, 8'h0F, 8'h00};
    words[0] = 8'hFF; words[1] = 8'h05; words[2] = 8'($urandom);
    for (int t = 0; t < 3; t++) begin
      word = words[t];
      cycle(1'b0, 1'b1, int'(coeffs[t]), 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 0, 1'b1, word[7-i]);
      n_cmp += 2;
      if (ParallelOut !== want[t]) begin
        n_err++; $display("FAIL small%0d_p got %h want %h", t, ParallelOut, want[t]);
      end
      if (ShiftRegB !== word) begin
        n_err++; $display("FAIL small%0d_b got %h want %h", t, ShiftRegB, word);
      end
    end
  endtask

  task automatic test_gap();
    logic [7:0] word = 8'hB2;
    cycle(1'b0, 1'b1, 'h56, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 0, 1'b1, word[7-i]);
    for (int g = 0; g < 3; g++) begin
      cycle(1'b0, 1'b0, int'($urandom_range(255)), 1'b0, 1'($urandom));
      n_cmp += 3;
      if (ParallelOut !== 8'hB2) begin
        n_err++; $display("FAIL gap%0d_p got %h want b2", g, ParallelOut);
      end
      if (ShiftRegB !== 8'h0B) begin n_err++; $display("FAIL gap%0d_b got %h want 0b", g, ShiftRegB); end
      if (ShiftRegA !== 8'h56) begin n_err++; $display("FAIL gap%0d_a got %h want 56", g, ShiftRegA); end
    end
    for (int i = 4; i < 8; i++) cycle(1'b0, 1'b0, 0, 1'b1, word[7-i]);
    n_cmp++;
    if (ParallelOut !== 8'hCC) begin n_err++; $display("FAIL gap_final got %h want cc", ParallelOut); end
  endtask

  task automatic test_priority();
    cycle(1'b0, 1'b1, 'h77, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 'h11, 1'b1, 1'b1);
    n_cmp += 3;
    if (ShiftRegA !== 8'h11) begin n_err++; $display("FAIL prio_load_a got %h want 11", ShiftRegA); end
    if (ParallelOut !== 8'h00) begin
      n_err++; $display("FAIL prio_load_p got %h want 00", ParallelOut);
    end
    if (ShiftRegB !== 8'h00) begin n_err++; $display("FAIL prio_load_b got %h want 00", ShiftRegB); end
    cycle(1'b0, 1'b0, 0, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 'h5A, 1'b1, 1'b1);
    n_cmp += 3;
    if (ShiftRegA !== 8'h00) begin n_err++; $display("FAIL prio_rst_a got %h want 00", ShiftRegA); end
    if (ParallelOut !== 8'h00) begin
      n_err++; $display("FAIL prio_rst_p got %h want 00", ParallelOut);
    end
    if (ShiftRegB !== 8'h00) begin n_err++; $display("FAIL prio_rst_b got %h want 00", ShiftRegB); end
    // After reset the coefficient is zero, so a step only moves the capture register.
    cycle(1'b0, 1'b0, 0, 1'b1, 1'b1);
    n_cmp += 2;
    if (ShiftRegB !== 8'h01) begin n_err++; $display("FAIL post_rst_b got %h want 01", ShiftRegB); end
    if (ParallelOut !== 8'h00) begin
      n_err++; $display("FAIL post_rst_p got %h want 00", ParallelOut);
    end
  endtask

  task automatic test_random();
    logic [7:0] coeff, word;
    int steps;
    for (int w = 0; w < 40; w++) begin
      coeff = 8'($urandom);
      word  = 8'($urandom);
      cycle(1'b0, 1'b1, int'(coeff), 1'($urandom), 1'($urandom));
      steps = 0;
      while (steps < 8) begin
        if ($urandom_range(3) == 0) begin
          cycle(1'b0, 1'b0, int'($urandom_range(255)), 1'b0, 1'($urandom));
        end else begin
          cycle(1'b0, 1'b0, int'($urandom_range(255)), 1'b1, word[7-steps]);
          steps++;
        end
        n_cmp += 3;
        if (ParallelOut !== 8'(m_p)) begin
          n_err++; $display("FAIL rand%0d_p got %h want %h", w, ParallelOut, 8'(m_p));
        end
        if (ShiftRegB !== 8'(m_b)) begin
          n_err++; $display("FAIL rand%0d_b got %h want %h", w, ShiftRegB, 8'(m_b));
        end
        if (ShiftRegA !== 8'(m_a)) begin
          n_err++; $display("FAIL rand%0d_a got %h want %h", w, ShiftRegA, 8'(m_a));
        end
      end
      n_cmp++;
      if (ParallelOut !== 8'((int'(coeff) * int'(word)) % 256)) begin
        n_err++;
        $display("FAIL rand%0d_product got %h want %h", w, ParallelOut,
                 8'((int'(coeff) * int'(word)) % 256));
      end
      // Extra bits keep accumulating as if appended to the word.
      if (w % 4 == 0) begin
        cycle(1'b0, 1'b0, 0, 1'b1, 1'b1);
        n_cmp++;
        if (ParallelOut !== 8'((int'(coeff) * (int'(word) * 2 + 1)) % 256)) begin
          n_err++;
          $display("FAIL rand%0d_extra got %h want %h", w, ParallelOut,
                   8'((int'(coeff) * (int'(word) * 2 + 1)) % 256));
        end
      end
    end
  endtask

  initial begin
    Reset = 1'b1; ParaLoad = 1'b0; CoeffData = '0; SerialIn = 1'b0; EnableShiftAdd = 1'b0;
    test_reset();
    test_basic();
    test_wrap_and_small();
    test_gap();
    test_priority();
    test_random();
    test_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
